// File: rtl/env_neighbourhood_fetcher.sv
// ============================================================================
// env_neighbourhood_fetcher: handshaked 8-neighbour + centre fetch from the grid.
// Optional macro: TORUS_WRAP_EN (toroidal grid, edge neighbours wrap).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module env_neighbourhood_fetcher #(
    parameter int X_bits       = 8,
    parameter int Y_bits       = 7,
    parameter int X_MAX        = 159,
    parameter int Y_MAX        = 119,
    parameter int SIGNAL_bits  = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                     newLocClock,
    input  logic                     RESET_SIM,
    input  logic                     start,
    input  logic [X_bits-1:0]        center_x,
    input  logic [Y_bits-1:0]        center_y,
    output logic                     busy,
    output logic                     done,
    output logic [X_bits-1:0]        lookup_X,
    output logic [Y_bits-1:0]        lookup_Y,
    input  logic                     lookup_sugar,
    input  logic [SIGNAL_bits-1:0]   lookup_signal,
    output logic [8*SIGNAL_bits-1:0] surrounding_signals,
    output logic                     cur_sugar,
    output logic [SIGNAL_bits-1:0]   cur_signal
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [X_bits-1:0] c_x_max = X_bits'(X_MAX);
    localparam logic [Y_bits-1:0] c_y_max = Y_bits'(Y_MAX);

    logic [1:0]               r_state;
    logic [3:0]               r_slot;
    logic [X_bits-1:0]        r_cx;
    logic [Y_bits-1:0]        r_cy;
    logic                     r_oob;
    logic [8*SIGNAL_bits-1:0] r_stage;

    // Capture pipe: tags each issued slot so its data lands L cycles later.
    logic [READ_LATENCY-1:0]  r_pv;
    logic [READ_LATENCY-1:0]  r_po;
    logic [3:0]               r_ps [READ_LATENCY];

    logic [X_bits-1:0]      w_sel_x;
    logic [Y_bits-1:0]      w_sel_y;
    logic [3:0]             w_sel_slot;
    logic [X_bits:0]        w_xm1, w_xp1;
    logic [Y_bits:0]        w_ym1, w_yp1;
    logic                   w_dxn, w_dxp, w_dyn, w_dyp;
    logic                   w_in_grid, w_oob;
    logic [X_bits-1:0]      w_nx;
    logic [Y_bits-1:0]      w_ny;
    logic                   w_tail_v, w_tail_oob;
    logic [3:0]             w_tail_slot;
    logic [SIGNAL_bits-1:0] w_cap_sig;

    // Address of the next slot to issue (slot 0 of the incoming centre while idle).
    always_comb begin
        w_sel_x    = (r_state == S_IDLE) ? center_x : r_cx;
        w_sel_y    = (r_state == S_IDLE) ? center_y : r_cy;
        w_sel_slot = (r_state == S_IDLE) ? 4'd0 : r_slot + 4'd1;
        w_xm1      = {1'b0, w_sel_x} - 1'b1;
        w_xp1      = {1'b0, w_sel_x} + 1'b1;
        w_ym1      = {1'b0, w_sel_y} - 1'b1;
        w_yp1      = {1'b0, w_sel_y} + 1'b1;
        w_dxn      = 1'b0;
        w_dxp      = 1'b0;
        w_dyn      = 1'b0;
        w_dyp      = 1'b0;
        case (w_sel_slot)
            4'd0:    w_dyn = 1'b1;
            4'd1:    begin w_dyn = 1'b1; w_dxp = 1'b1; end
            4'd2:    w_dxp = 1'b1;
            4'd3:    begin w_dxp = 1'b1; w_dyp = 1'b1; end
            4'd4:    w_dyp = 1'b1;
            4'd5:    begin w_dyp = 1'b1; w_dxn = 1'b1; end
            4'd6:    w_dxn = 1'b1;
            4'd7:    begin w_dxn = 1'b1; w_dyn = 1'b1; end
            default: ;
        endcase
        w_in_grid = (w_sel_x <= c_x_max) && (w_sel_y <= c_y_max);
`ifdef TORUS_WRAP_EN
        w_oob = !w_in_grid;
        w_nx  = w_sel_x;
        w_ny  = w_sel_y;
        if (!w_oob) begin
            if (w_dxn)      w_nx = w_xm1[X_bits] ? c_x_max : w_xm1[X_bits-1:0];
            else if (w_dxp) w_nx = (w_xp1 > {1'b0, c_x_max}) ? '0 : w_xp1[X_bits-1:0];
            if (w_dyn)      w_ny = w_ym1[Y_bits] ? c_y_max : w_ym1[Y_bits-1:0];
            else if (w_dyp) w_ny = (w_yp1 > {1'b0, c_y_max}) ? '0 : w_yp1[Y_bits-1:0];
        end
`else
        w_oob = !w_in_grid
              || (w_dxn && w_xm1[X_bits]) || (w_dxp && (w_xp1 > {1'b0, c_x_max}))
              || (w_dyn && w_ym1[Y_bits]) || (w_dyp && (w_yp1 > {1'b0, c_y_max}));
        w_nx  = w_sel_x;
        w_ny  = w_sel_y;
        if (!w_oob) begin
            if (w_dxn)      w_nx = w_xm1[X_bits-1:0];
            else if (w_dxp) w_nx = w_xp1[X_bits-1:0];
            if (w_dyn)      w_ny = w_ym1[Y_bits-1:0];
            else if (w_dyp) w_ny = w_yp1[Y_bits-1:0];
        end
`endif
        w_tail_v    = r_pv[READ_LATENCY-1];
        w_tail_oob  = r_po[READ_LATENCY-1];
        w_tail_slot = r_ps[READ_LATENCY-1];
        w_cap_sig   = w_tail_oob ? '0 : lookup_signal;
    end

    always_ff @(posedge newLocClock or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            r_state             <= S_IDLE;
            r_slot              <= '0;
            r_cx                <= '0;
            r_cy                <= '0;
            r_oob               <= 1'b0;
            r_stage             <= '0;
            r_pv                <= '0;
            r_po                <= '0;
            for (int i = 0; i < READ_LATENCY; i++) r_ps[i] <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
            lookup_X            <= '0;
            lookup_Y            <= '0;
            surrounding_signals <= '0;
            cur_sugar           <= 1'b0;
            cur_signal          <= '0;
        end else begin
            done    <= 1'b0;
            r_pv[0] <= (r_state == S_ISSUE);
            r_ps[0] <= r_slot;
            r_po[0] <= r_oob;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_ps[i] <= r_ps[i-1];
                r_po[i] <= r_po[i-1];
            end
            if (w_tail_v && (w_tail_slot != 4'd8))
                r_stage[w_tail_slot[2:0]*SIGNAL_bits +: SIGNAL_bits] <= w_cap_sig;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cx     <= center_x;
                        r_cy     <= center_y;
                        r_slot   <= 4'd0;
                        lookup_X <= w_nx;
                        lookup_Y <= w_ny;
                        r_oob    <= w_oob;
                        busy     <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_slot == 4'd8) begin
                        r_state <= S_DRAIN;
                    end else begin
                        r_slot   <= r_slot + 4'd1;
                        lookup_X <= w_nx;
                        lookup_Y <= w_ny;
                        r_oob    <= w_oob;
                    end
                end
                S_DRAIN: begin
                    // Centre data arrives last; publish the whole neighbourhood at once.
                    if (w_tail_v && (w_tail_slot == 4'd8)) begin
                        surrounding_signals <= r_stage;
                        cur_signal          <= w_cap_sig;
                        cur_sugar           <= !w_tail_oob && lookup_sugar;
                        done                <= 1'b1;
                        busy                <= 1'b0;
                        r_state             <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_env_neighbourhood_fetcher.sv
// ============================================================================
// tb_env_neighbourhood_fetcher: four DUTs (READ_LATENCY 1..4) on shared stimulus,
// checked against a coordinate-level neighbourhood model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_env_neighbourhood_fetcher;

    localparam int XM = 159;
    localparam int YM = 119;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cx_in;
    logic [6:0]  cy_in;
    logic [3:0]  busy, done;
    logic [7:0]  lx   [4];
    logic [6:0]  ly   [4];
    logic [31:0] surr [4];
    logic [3:0]  csig [4];
    logic [3:0]  csug;

    int total = 0;
    int bad   = 0;
    int salt  = 0;

    int          exp_ax [9];
    int          exp_ay [9];
    logic [31:0] exp_surr, prev_surr;
    logic [3:0]  exp_csig, prev_csig;
    logic        exp_csug, prev_csug;

    always #5 clk = ~clk;

    function automatic int msig(input int x, input int y);
        return (x + y + salt) & 15;
    endfunction

    function automatic bit msug(input int x, input int y);
        if (salt == 0) return (x == y);
        return bit'((x + y + salt) & 1);
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        localparam int L = gi + 1;
        logic [3:0] mem_s [4];
        logic       mem_g [4];

        env_neighbourhood_fetcher #(.READ_LATENCY(L)) u_dut (
            .newLocClock        (clk),
            .RESET_SIM          (rst),
            .start              (start),
            .center_x           (cx_in),
            .center_y           (cy_in),
            .busy               (busy[gi]),
            .done               (done[gi]),
            .lookup_X           (lx[gi]),
            .lookup_Y           (ly[gi]),
            .lookup_sugar       (mem_g[L-1]),
            .lookup_signal      (mem_s[L-1]),
            .surrounding_signals(surr[gi]),
            .cur_sugar          (csug[gi]),
            .cur_signal         (csig[gi])
        );

        // Grid memory: data for the address seen at an edge appears L edges later.
        always @(posedge clk) begin
            mem_s[0] <= 4'(msig(int'(lx[gi]), int'(ly[gi])));
            mem_g[0] <= msug(int'(lx[gi]), int'(ly[gi]));
            for (int j = 1; j < 4; j++) begin
                mem_s[j] <= mem_s[j-1];
                mem_g[j] <= mem_g[j-1];
            end
        end
    end

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s L=%0d got=%0h want=%0h", tag, i + 1, obs, expv);
        end
    endtask

    // Neighbour k of (cx,cy): slot order N,NE,E,SE,S,SW,W,NW,centre.
    task automatic ref_slot(input int cx, input int cy, input int k, output int ax, output int ay, output bit oob);
        int dx, dy, nx, ny;
        bit ing;
        dx  = (k >= 1 && k <= 3) ? 1 : (k >= 5 && k <= 7) ? -1 : 0;
        dy  = (k <= 1 || k == 7) ? -1 : (k >= 3 && k <= 5) ? 1 : 0;
        nx  = cx + dx;
        ny  = cy + dy;
        ing = (cx <= XM) && (cy <= YM);
`ifdef TORUS_WRAP_EN
        oob = !ing;
        nx  = (nx + XM + 1) % (XM + 1);
        ny  = (ny + YM + 1) % (YM + 1);
`else
        oob = !ing || nx < 0 || nx > XM || ny < 0 || ny > YM;
`endif
        ax = oob ? cx : nx;
        ay = oob ? cy : ny;
    endtask

    task automatic calc(input int cx, input int cy);
        bit oob;
        for (int k = 0; k < 9; k++) begin
            ref_slot(cx, cy, k, exp_ax[k], exp_ay[k], oob);
            if (k < 8) exp_surr[k*4 +: 4] = oob ? 4'd0 : 4'(msig(exp_ax[k], exp_ay[k]));
            else begin
                exp_csig = oob ? 4'd0 : 4'(msig(exp_ax[k], exp_ay[k]));
                exp_csug = oob ? 1'b0 : msug(exp_ax[k], exp_ay[k]);
            end
        end
    endtask

    task automatic chk_outs(input string tag, input int i, input logic [31:0] s, input logic [3:0] c, input logic g);
        chk({tag, "_surr"}, i, surr[i], s);
        chk({tag, "_csig"}, i, 32'(csig[i]), 32'(c));
        chk({tag, "_csug"}, i, 32'(csug[i]), 32'(g));
    endtask

    task automatic do_fetch(input int cx, input int cy, input bit pulses);
        calc(cx, cy);
        @(negedge clk);
        start = 1'b1; cx_in = 8'(cx); cy_in = 7'(cy);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; cx_in = 8'($urandom); cy_in = 7'($urandom);
        for (int n = 0; n < 15; n++) begin
            for (int i = 0; i < 4; i++) begin
                chk("busy", i, 32'(busy[i]), 32'(n < 10 + i));
                chk("done", i, 32'(done[i]), 32'(n == 10 + i));
                if (n <= 8) begin
                    chk("addr_x", i, 32'(lx[i]), exp_ax[n]);
                    chk("addr_y", i, 32'(ly[i]), exp_ay[n]);
                end
                if (n < 10 + i) chk_outs("hold", i, prev_surr, prev_csig, prev_csug);
                else            chk_outs("res", i, exp_surr, exp_csig, exp_csug);
            end
            if (pulses) start = (n == 2 || n == 4 || n == 9);
            @(negedge clk);
        end
        start = 1'b0;
        if (pulses)
            for (int n = 0; n < 15; n++) begin
                for (int i = 0; i < 4; i++) chk("extra_done", i, 32'(done[i]), 32'd0);
                @(negedge clk);
            end
        prev_surr = exp_surr; prev_csig = exp_csig; prev_csug = exp_csug;
    endtask

    task automatic held_test(input int cx, input int cy);
        int dt [4][6];
        int cnt [4];
        int want;
        calc(cx, cy);
        cnt = '{0, 0, 0, 0};
        @(negedge clk);
        start = 1'b1; cx_in = 8'(cx); cy_in = 7'(cy);
        @(posedge clk);
        @(negedge clk);
        for (int n = 0; n < 48; n++) begin
            for (int i = 0; i < 4; i++)
                if (done[i]) begin
                    if (cnt[i] < 6) dt[i][cnt[i]] = n;
                    cnt[i]++;
                    chk_outs("held", i, exp_surr, exp_csig, exp_csug);
                end
            if (n == 47) start = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            want = 0;
            while (10 + i + want * (11 + i) < 48) want++;
            chk("held_count", i, cnt[i], want);
            for (int m = 0; m < cnt[i] && m < 6; m++)
                chk("held_time", i, dt[i][m], 10 + i + m * (11 + i));
        end
        repeat (20) @(negedge clk);
        prev_surr = exp_surr; prev_csig = exp_csig; prev_csug = exp_csug;
    endtask

    task automatic chk_zero(input string tag);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, i, 32'(busy[i]), 32'd0);
            chk({tag, "_done"}, i, 32'(done[i]), 32'd0);
            chk({tag, "_lx"}, i, 32'(lx[i]), 32'd0);
            chk({tag, "_ly"}, i, 32'(ly[i]), 32'd0);
            chk_outs(tag, i, 32'd0, 4'd0, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; cx_in = '0; cy_in = '0;
        prev_surr = '0; prev_csig = '0; prev_csug = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        do_fetch(10, 10, 1'b0);
        chk("interior_surr", 0, surr[0], 32'h23456543);
        chk("interior_csig", 0, 32'(csig[0]), 32'd4);
        chk("interior_csug", 0, 32'(csug[0]), 32'd1);

        do_fetch(0, 0, 1'b0);
`ifdef TORUS_WRAP_EN
        chk("corner_surr", 0, surr[0], 32'h6F012187);
`else
        chk("corner_surr", 0, surr[0], 32'h00012100);
`endif
        chk("corner_csig", 0, 32'(csig[0]), 32'd0);

        do_fetch(50, 60, 1'b1);
        do_fetch(159, 119, 1'b0);
        do_fetch(160, 5, 1'b0);
        chk("oog_surr", 0, surr[0], 32'd0);
        chk("oog_csig", 0, 32'(csig[0]), 32'd0);

        salt = 5;
        held_test(20, 30);

        // Abort on the fifth issue cycle.
        @(negedge clk);
        start = 1'b1; cx_in = 8'd30; cy_in = 7'd40;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_zero("abort");
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 15; n++) begin
            for (int i = 0; i < 4; i++) chk("abort_done", i, 32'(done[i]), 32'd0);
            @(negedge clk);
        end
        prev_surr = '0; prev_csig = '0; prev_csug = 1'b0;
        do_fetch(7, 100, 1'b0);

        for (int r = 0; r < 8; r++) begin
            salt = int'($urandom_range(0, 15));
            do_fetch(int'($urandom_range(0, XM + 2)), int'($urandom_range(0, YM + 2)), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
